// File: rtl/traffic_pkg.sv
// Shared phase encoding, LED polarity and elaboration helpers for the traffic signal sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED   = 2'b00,
        AMB   = 2'b01,
        GRN   = 2'b10,
        FLASH = 2'b11
    } phase_t;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_signal_ctrl_phase_timer.sv
// Phase counter: clears to zero on request, otherwise counts up and saturates instead of wrapping.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

    // >= rather than == so an overshoot still ends the phase
    assign expire = (count >= last);

endmodule

// File: rtl/traffic_signal_ctrl.sv
// Single-approach traffic signal sequencer with pedestrian request, night flash and walk output.
module traffic_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned RED_TICKS     = 240_000_000,
    parameter int unsigned GRN_TICKS     = 120_000_000,
    parameter int unsigned AMB_TICKS     = 48_000_000,
    parameter int unsigned MIN_GRN_TICKS = 36_000_000,
    parameter int unsigned FLASH_TICKS   = 12_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       ped_walk,
    output logic [1:0] phase
);

    localparam int MAX_T = max_of(max_of(int'(RED_TICKS), int'(GRN_TICKS)),
                                  max_of(int'(AMB_TICKS),
                                         max_of(int'(MIN_GRN_TICKS), int'(FLASH_TICKS))));
    localparam int CNT_W = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GRN_LAST   = CNT_W'(GRN_TICKS - 1);
    localparam logic [CNT_W-1:0] AMB_LAST   = CNT_W'(AMB_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GRN_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);

    phase_t           phase_q, phase_nx;
    logic             pending, pending_nx;
    logic             walk_nx;
    logic             flash_nx;
    logic             red_nx, green_nx, blue_nx;
    logic             pend_eff;
    logic             clear;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] count;
    logic             expire;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .last   (last),
        .count  (count),
        .expire (expire)
    );

    always_comb begin
        last = RED_LAST;
        case (phase_q)
            GRN:     last = GRN_LAST;
            AMB:     last = AMB_LAST;
            FLASH:   last = FLASH_LAST;
            default: last = RED_LAST;
        endcase
    end

    // A request raised in the deciding cycle counts immediately, not one cycle later
    assign pend_eff = pending | ped_req;

    always_comb begin
        phase_nx   = phase_q;
        pending_nx = pending;
        walk_nx    = ped_walk;
        flash_nx   = blue;
        clear      = 1'b0;
        if (night_mode) begin
            pending_nx = 1'b0;
            walk_nx    = 1'b0;
            if (phase_q != FLASH) begin
                phase_nx = FLASH;
                flash_nx = LED_ON;
                clear    = 1'b1;
            end else if (expire) begin
                flash_nx = ~blue;
                clear    = 1'b1;
            end
        end else begin
            case (phase_q)
                RED: begin
                    pending_nx = pend_eff;
                    if (expire) begin
                        phase_nx = GRN;
                        walk_nx  = 1'b0;
                        clear    = 1'b1;
                    end
                end
                GRN: begin
                    pending_nx = pend_eff;
                    if (expire || (pend_eff && count >= MIN_LAST)) begin
                        phase_nx = AMB;
                        clear    = 1'b1;
                    end
                end
                AMB: begin
                    pending_nx = pend_eff;
                    if (expire) begin
                        phase_nx   = RED;
                        clear      = 1'b1;
                        walk_nx    = pend_eff;
                        pending_nx = 1'b0;
                    end
                end
                default: begin
                    phase_nx   = RED;
                    clear      = 1'b1;
                    pending_nx = 1'b0;
                    walk_nx    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        red_nx   = LED_OFF;
        green_nx = LED_OFF;
        blue_nx  = LED_OFF;
        case (phase_nx)
            RED:     red_nx   = LED_ON;
            GRN:     green_nx = LED_ON;
            AMB:     blue_nx  = LED_ON;
            default: blue_nx  = flash_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= RED;
            pending  <= 1'b0;
            ped_walk <= 1'b0;
            red      <= LED_ON;
            green    <= LED_OFF;
            blue     <= LED_OFF;
        end else begin
            phase_q  <= phase_nx;
            pending  <= pending_nx;
            ped_walk <= walk_nx;
            red      <= red_nx;
            green    <= green_nx;
            blue     <= blue_nx;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// Randomised scoreboard bench for traffic_signal_ctrl against a phase-duration reference model.
module tb_traffic_signal_ctrl;

    localparam int T_RED   = 5;
    localparam int T_GRN   = 8;
    localparam int T_AMB   = 2;
    localparam int T_MIN   = 3;
    localparam int T_FLASH = 2;

    localparam int P_RED   = 0;
    localparam int P_GRN   = 1;
    localparam int P_AMB   = 2;
    localparam int P_FLASH = 3;

    typedef struct packed {
        logic       red;
        logic       green;
        logic       blue;
        logic       walk;
        logic [1:0] ph;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic       red, green, blue, ped_walk;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    bit stim_done = 1'b0;
    obs_t exp_q[$];

    // Reference model: which phase is showing, how many cycles it has already shown
    int m_ph;
    int m_el;
    bit m_pend;
    bit m_walk;
    bit m_flash_lit;

    traffic_signal_ctrl #(
        .RED_TICKS     (T_RED),
        .GRN_TICKS     (T_GRN),
        .AMB_TICKS     (T_AMB),
        .MIN_GRN_TICKS (T_MIN),
        .FLASH_TICKS   (T_FLASH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .ped_walk   (ped_walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        obs_t o;
        o.red = red; o.green = green; o.blue = blue; o.walk = ped_walk; o.ph = phase;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.red   = (m_ph == P_RED) ? 1'b0 : 1'b1;
        o.green = (m_ph == P_GRN) ? 1'b0 : 1'b1;
        o.blue  = (m_ph == P_AMB) ? 1'b0 : (m_ph == P_FLASH) ? !m_flash_lit : 1'b1;
        o.walk  = m_walk;
        case (m_ph)
            P_RED:   o.ph = 2'b00;
            P_GRN:   o.ph = 2'b10;
            P_AMB:   o.ph = 2'b01;
            default: o.ph = 2'b11;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got r=%b g=%b b=%b walk=%b ph=%b want r=%b g=%b b=%b walk=%b ph=%b",
                     name, cycle, act.red, act.green, act.blue, act.walk, act.ph,
                     exp.red, exp.green, exp.blue, exp.walk, exp.ph);
        end
    endtask

    task automatic model_reset();
        m_ph = P_RED; m_el = 0; m_pend = 0; m_walk = 0; m_flash_lit = 0;
    endtask

    task automatic model_step(input bit ped, input bit night);
        if (night) begin
            if (m_ph != P_FLASH) begin
                m_ph = P_FLASH; m_el = 0; m_flash_lit = 1;
            end else if (m_el + 1 == T_FLASH) begin
                m_flash_lit = !m_flash_lit; m_el = 0;
            end else begin
                m_el++;
            end
            m_pend = 0; m_walk = 0;
        end else begin
            case (m_ph)
                P_FLASH: begin m_ph = P_RED; m_el = 0; end
                P_RED: begin
                    m_pend |= ped;
                    if (m_el + 1 == T_RED) begin m_ph = P_GRN; m_el = 0; m_walk = 0; end
                    else m_el++;
                end
                P_GRN: begin
                    m_pend |= ped;
                    if (m_el + 1 == T_GRN || (m_pend && m_el + 1 >= T_MIN)) begin
                        m_ph = P_AMB; m_el = 0;
                    end else m_el++;
                end
                default: begin
                    m_pend |= ped;
                    if (m_el + 1 == T_AMB) begin
                        m_ph = P_RED; m_el = 0; m_walk = m_pend; m_pend = 0;
                    end else m_el++;
                end
            endcase
        end
    endtask

    task automatic drive_cycle(input bit ped, input bit night, input bit rstn);
        obs_t rst_vals;
        rst_vals = '{red: 1'b0, green: 1'b1, blue: 1'b1, walk: 1'b0, ph: 2'b00};
        @(negedge clk);
        ped_req = ped;
        night_mode = night;
        if (!rstn) begin
            model_reset();
            if (rst_n) begin
                rst_n = 1'b0;
                #1;
                check("async_reset", dut_obs(), rst_vals);
            end
        end else begin
            rst_n = 1'b1;
            model_step(ped, night);
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic wait_for(input int ph, input int el, input string name);
        int n = 0;
        while (!(m_ph == ph && m_el == el) && n < 100) begin
            drive_cycle(0, 0, 1);
            n++;
        end
        if (!(m_ph == ph && m_el == el)) begin
            checks++; errors++;
            $display("FAIL wait_%s phase=%0d count=%0d required phase=%0d count=%0d", name, m_ph, m_el, ph, el);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 1);
    endtask

    // Monitor: every clock the registered outputs present one new sample
    initial begin
        obs_t e;
        while (!stim_done || exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outputs", dut_obs(), e);
            end
        end
    end

    initial begin
        bit night_lvl;
        model_reset();
        #2;
        drive_cycle(0, 0, 0);
        idle(35);
        wait_for(P_GRN, 0, "grn0");
        drive_cycle(1, 0, 1);
        idle(20);
        wait_for(P_GRN, 6, "grn6");
        drive_cycle(1, 0, 1);
        wait_for(P_RED, 2, "red_walk");
        drive_cycle(1, 0, 1);
        idle(30);
        wait_for(P_GRN, 3, "grn3");
        for (int i = 0; i < 9; i++) drive_cycle(i[0], 1, 1);
        idle(12);
        wait_for(P_AMB, 0, "amb0");
        drive_cycle(0, 0, 0);
        idle(10);
        wait_for(P_GRN, 7, "grn_last");
        for (int i = 0; i < 4; i++) drive_cycle(0, 1, 1);
        idle(6);
        wait_for(P_AMB, 1, "amb_last");
        drive_cycle(1, 0, 1);
        idle(12);
        night_lvl = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) night_lvl = !night_lvl;
            drive_cycle($urandom_range(0, 7) == 0, night_lvl, $urandom_range(0, 299) != 0);
        end
        drive_cycle(0, 0, 1);
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
